regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file; successor to the core's fixed 32×32 single-write-port file. Provides two asynchronous read ports, two prioritised write ports and one debug read port. A sequenced bulk-clear engine zeroes the array without a global reset. Sits between decode (reads), writeback (two retiring results per cycle) and the debug/trace unit.

## Interface
- XLEN, 32, data width in bits (≥8)
- NREGS, 32, number of architectural registers (power of 2, ≥4)
- AW, $clog2(NREGS), address width (derived, not overridden)
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes

- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rs1_addr, rs2_addr  in  AW each  read port addresses
- rs1_data, rs2_data  out  XLEN each  read data (combinational)
- wp0_en, wp1_en  in  1 each  write enables
- wp0_addr, wp1_addr  in  AW each  write addresses
- wp0_data, wp1_data  in  XLEN each  write data
- dbg_addr  in  AW  debug read address
- dbg_data  out  XLEN  debug read data (combinational, never bypassed)
- clear_req  in  1  start bulk clear (level sampled at the clock edge)
- clear_busy  out  1  clear sweep in progress
- clear_done  out  1  one-cycle pulse when the sweep completes

## Operation
- Reset (reset_n=0, asynchronous): all NREGS entries become 0. FSM goes to IDLE. Sweep counter becomes 0. clear_busy=0, clear_done=0. Read outputs then reflect the zeroed array.
- Reads: rsN_data = array[rsN_addr]. Forced to 0 when ZERO_REG=1 and the address is 0.
- Writes, in IDLE only: each enabled port writes its address at the edge.
  - Writes to address 0 are dropped when ZERO_REG=1.
  - If wp0_addr==wp1_addr and both ports are enabled, wp1 wins and wp0 is discarded.
  - Different addresses are both written in the same cycle.
- FSM has two states, IDLE and CLEAR.
  - IDLE→CLEAR when clear_req=1 at an edge. Writes presented in that same cycle are still performed.
  - In CLEAR, at each edge the entry at index cnt is set to 0 and cnt increments.
  - CLEAR→IDLE at the edge where cnt==NREGS-1. That same edge asserts clear_done for one cycle and resets cnt to 0.
- In CLEAR:
  - Both write ports are ignored, and the dropped writes are not queued.
  - clear_req is ignored.
  - Reads return current array contents, so a mix of cleared and uncleared entries is visible.
- Reset asserted mid-sweep: the array is zeroed, the FSM returns to IDLE, and no clear_done is produced.

## Timing
- Read latency is 0 cycles (combinational from address).
- A write is visible on read ports from the cycle after its edge. With bypass compiled in, it is visible in the same cycle (see Configuration).
- A clear_req sampled at edge E:
  - clear_busy=1 from E until edge E+NREGS.
  - clear_done=1 for the single cycle following edge E+NREGS.
  - Total time is NREGS busy cycles.
- A clear_req in the cycle where clear_done=1 starts a new sweep at that edge.
- All outputs are glitch-free registered state, except the read/debug data paths.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined:
  - In IDLE, a read port whose address matches an enabled write port returns that port's write data in the same cycle.
  - wp1 takes priority over wp0 when both match.
  - ZERO_REG suppression still applies to address 0.
  - No bypass in CLEAR, because writes are dropped there.
  - dbg_data is never bypassed.
- Undefined: read ports return the pre-write array value during the write cycle.

## Test plan
- Reset then dual write: reset_n low, then high. At one edge, wp0 (addr 5, 0xDEADBEEF) and wp1 (addr 6, 0x12345678). Next cycle rs1_addr=5 → 0xDEADBEEF, rs2_addr=6 → 0x12345678, dbg_addr=7 → 0.
- Same-address conflict: wp0 (addr 9, 0x1111) and wp1 (addr 9, 0x2222) in one cycle → addr 9 reads 0x2222.
- Zero register: with ZERO_REG=1, wp0 (addr 0, 0xFFFFFFFF) → rs1_addr=0 reads 0.
- Bypass: write addr 3, 0xA5A5A5A5, with rs1_addr=3 in the same cycle.
  - With REGFILE_BYPASS_EN → rs1_data=0xA5A5A5A5 in that cycle.
  - Without it → old value (0) that cycle and 0xA5A5A5A5 the next cycle.
- Bulk clear: fill all registers with 0x100+i, then pulse clear_req.
  - clear_busy stays high exactly 32 cycles (NREGS=32).
  - A write of 0x55 to addr 4 mid-sweep is dropped.
  - clear_done pulses once.
  - All registers then read 0.
- Reset mid-clear: start a sweep, then drop reset_n after 10 cycles → all registers 0, clear_busy=0, and no clear_done pulse is ever seen.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two combinational read ports, two prioritised
// write ports, a debug read port and a sequenced bulk-clear engine. Optional macro: REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wp0_en,
    input  logic            wp1_en,
    input  logic [AW-1:0]   wp0_addr,
    input  logic [AW-1:0]   wp1_addr,
    input  logic [XLEN-1:0] wp0_data,
    input  logic [XLEN-1:0] wp1_data,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    input  logic            clear_req,
    output logic            clear_busy,
    output logic            clear_done
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [XLEN-1:0] regs [NREGS];
    logic            wr0_ok;
    logic            wr1_ok;

    always_comb begin
        wr0_ok = wp0_en && (state == IDLE) && !((ZERO_REG != 0) && (wp0_addr == '0));
        wr1_ok = wp1_en && (state == IDLE) && !((ZERO_REG != 0) && (wp1_addr == '0));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            state      <= IDLE;
            cnt        <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    // wp1 is assigned last so it wins a same-address conflict
                    if (wr0_ok) regs[wp0_addr] <= wp0_data;
                    if (wr1_ok) regs[wp1_addr] <= wp1_data;
                    if (clear_req) begin
                        state      <= CLEAR;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    regs[cnt] <= '0;
                    if (cnt == AW'(NREGS - 1)) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr0_ok && (wp0_addr == rs1_addr)) rs1_data = wp0_data;
        if (wr1_ok && (wp1_addr == rs1_addr)) rs1_data = wp1_data;
`endif
        if ((ZERO_REG != 0) && (rs1_addr == '0)) rs1_data = '0;
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr0_ok && (wp0_addr == rs2_addr)) rs2_data = wp0_data;
        if (wr1_ok && (wp1_addr == rs2_addr)) rs2_data = wp1_data;
`endif
        if ((ZERO_REG != 0) && (rs2_addr == '0)) rs2_data = '0;
    end

    always_comb begin
        dbg_data = regs[dbg_addr];
        if ((ZERO_REG != 0) && (dbg_addr == '0)) dbg_data = '0;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: expected read values are queued when
// addresses are driven and compared once the combinational outputs settle.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [AW-1:0]   rs1_addr, rs2_addr, dbg_addr;
    logic [XLEN-1:0] rs1_data, rs2_data, dbg_data;
    logic            wp0_en, wp1_en;
    logic [AW-1:0]   wp0_addr, wp1_addr;
    logic [XLEN-1:0] wp0_data, wp1_data;
    logic            clear_req, clear_busy, clear_done;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wp0_en(wp0_en), .wp1_en(wp1_en),
        .wp0_addr(wp0_addr), .wp1_addr(wp1_addr),
        .wp0_data(wp0_data), .wp1_data(wp1_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done)
    );

    typedef struct {
        string           tag;
        logic [XLEN-1:0] exp;
    } exp_t;

    exp_t            sb[$];
    int              n_checks = 0;
    int              n_pass   = 0;
    logic [XLEN-1:0] model [NREGS];

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic push(input string tag, input logic [XLEN-1:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [XLEN-1:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic read3(input int a1, input int a2, input int ad, input string tag);
        rs1_addr = AW'(a1);
        rs2_addr = AW'(a2);
        dbg_addr = AW'(ad);
        push({tag, "_rs1"}, model[a1]);
        push({tag, "_rs2"}, model[a2]);
        push({tag, "_dbg"}, model[ad]);
        #1;
        pop_check(rs1_data);
        pop_check(rs2_data);
        pop_check(dbg_data);
    endtask

    task automatic write2(input bit e0, input int a0, input logic [XLEN-1:0] d0,
                          input bit e1, input int a1, input logic [XLEN-1:0] d1);
        @(negedge clk);
        wp0_en = e0; wp0_addr = AW'(a0); wp0_data = d0;
        wp1_en = e1; wp1_addr = AW'(a1); wp1_data = d1;
        @(posedge clk);
        #1;
        wp0_en = 1'b0;
        wp1_en = 1'b0;
        if (e0 && a0 != 0) model[a0] = d0;
        if (e1 && a1 != 0) model[a1] = d1;
    endtask

    initial begin
        int busy_cnt, done_cnt;

        reset_n = 1'b0; clear_req = 1'b0;
        wp0_en = 1'b0; wp1_en = 1'b0;
        wp0_addr = '0; wp1_addr = '0; wp0_data = '0; wp1_data = '0;
        rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, clear_busy}, 0);
        check("rst_done", {31'b0, clear_done}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        read3(0, 1, 31, "rst");

        write2(1, 5, 32'hDEADBEEF, 1, 6, 32'h12345678);
        read3(5, 6, 7, "dual");

        write2(1, 9, 32'h1111, 1, 9, 32'h2222);
        read3(9, 9, 9, "conflict");

        write2(1, 0, 32'hFFFFFFFF, 0, 0, '0);
        read3(0, 0, 0, "zero");

        // Bypass: read the address being written in the same cycle
        @(negedge clk);
        wp0_en = 1'b1; wp0_addr = 5'd3; wp0_data = 32'hA5A5A5A5; rs1_addr = 5'd3;
`ifdef REGFILE_BYPASS_EN
        push("byp_same", 32'hA5A5A5A5);
`else
        push("byp_same", model[3]);
`endif
        #1;
        pop_check(rs1_data);
        @(posedge clk);
        #1;
        wp0_en = 1'b0;
        model[3] = 32'hA5A5A5A5;
        push("byp_next", model[3]);
        pop_check(rs1_data);

        for (int i = 0; i < NREGS; i += 2)
            write2(1, i, 32'h100 + i, 1, i + 1, 32'h101 + i);
        read3(1, 17, 31, "fill");

        // Bulk clear sweep
        @(negedge clk);
        clear_req = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (clear_busy) busy_cnt++;
            if (clear_done) done_cnt++;
            if (i == 0) begin
                clear_req = 1'b0;
                check("clr_busy_start", {31'b0, clear_busy}, 1);
            end
            if (i == 5) begin
                rs1_addr = 5'd31;
                rs2_addr = 5'd2;
                push("clr_mid_uncleared", 32'h11F);
                push("clr_mid_cleared", 32'h0);
                #1;
                pop_check(rs1_data);
                pop_check(rs2_data);
            end
            if (i == 7) begin
                wp0_en = 1'b1; wp0_addr = 5'd4; wp0_data = 32'h55;
            end
            if (i == 8) wp0_en = 1'b0;
        end
        check("clr_busy_cycles", busy_cnt, NREGS);
        check("clr_done_pulses", done_cnt, 1);
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        for (int i = 0; i < NREGS; i++) read3(i, (i + 16) % NREGS, i, "clr_all");

        // Reset in the middle of a sweep
        write2(1, 20, 32'hABC, 1, 25, 32'hDEF);
        @(negedge clk);
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("rstmid_busy", {31'b0, clear_busy}, 0);
        check("rstmid_done", {31'b0, clear_done}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (clear_busy) busy_cnt++;
            if (clear_done) done_cnt++;
        end
        check("rstmid_busy_after", busy_cnt, 0);
        check("rstmid_no_done", done_cnt, 0);
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        read3(20, 25, 20, "rstmid_a");
        read3(15, 31, 9, "rstmid_b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
